// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx
// Purpose  : Host-to-device PS/2 command transmitter, open-drain on shared pins.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int CNT_W          = 21
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DATA,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_REQ       = 3'd2,
        S_SEND      = 3'd3,
        S_WAIT_ACK  = 3'd4,
        S_WAIT_IDLE = 3'd5,
        S_DONE      = 3'd6,
        S_ERR       = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] c_inhibit_last = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one      = CNT_W'(1);
    localparam logic [3:0]       c_last_idx     = 4'd9;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       idx_q, idx_d;
    logic [10:0]      frame_q, frame_d;

    logic clk_meta_q, clk_meta_d;
    logic clk_sync_q, clk_sync_d;
    logic clk_prev_q, clk_prev_d;
    logic data_meta_q, data_meta_d;
    logic data_sync_q, data_sync_d;

    logic w_fe;
    logic w_timeout;
    logic w_clk_low;
    logic w_data_low;

    // Two-stage synchronizers plus one extra stage for falling-edge detection
    always_comb begin
        clk_meta_d  = PS2_CLK;
        clk_sync_d  = clk_meta_q;
        clk_prev_d  = clk_sync_q;
        data_meta_d = PS2_DATA;
        data_sync_d = data_meta_q;
    end

    assign w_fe      = clk_prev_q & ~clk_sync_q;
    assign w_timeout = (cnt_q == c_timeout_last);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        frame_d = frame_q;

        case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    // frame[0] is the start bit so frame[idx] is always the bit on the wire
                    frame_d = {1'b1, ~^tx_data, tx_data, 1'b0};
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                if (cnt_q == c_inhibit_last) begin
                    cnt_d   = '0;
                    state_d = S_REQ;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end

            S_REQ: begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = S_SEND;
            end

            S_SEND: begin
                if (w_timeout) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                    if (w_fe) begin
                        idx_d = idx_q + 4'd1;
                        if (idx_q == c_last_idx) begin
                            state_d = S_WAIT_ACK;
                        end
                    end
                end
            end

            S_WAIT_ACK: begin
                if (w_timeout) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                    if (w_fe) begin
                        state_d = data_sync_q ? S_ERR : S_WAIT_IDLE;
                    end
                end
            end

            S_WAIT_IDLE: begin
                if (w_timeout) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                    if (clk_sync_q && data_sync_q) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            S_ERR: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            frame_q     <= '0;
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            frame_q     <= frame_d;
            clk_meta_q  <= clk_meta_d;
            clk_sync_q  <= clk_sync_d;
            clk_prev_q  <= clk_prev_d;
            data_meta_q <= data_meta_d;
            data_sync_q <= data_sync_d;
        end
    end

    // Pin drive decodes straight from state so an async reset releases the lines at once
    always_comb begin
        w_clk_low  = (state_q == S_INHIBIT) || (state_q == S_REQ);
        w_data_low = (state_q == S_REQ) || ((state_q == S_SEND) && !frame_q[idx_q]);
        tx_ready   = (state_q == S_IDLE);
        busy       = (state_q != S_IDLE);
        tx_done    = (state_q == S_DONE);
        tx_err     = (state_q == S_ERR);
    end

    assign PS2_CLK  = w_clk_low  ? 1'b0 : 1'bz;
    assign PS2_DATA = w_data_low ? 1'b0 : 1'bz;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_host_tx
// Purpose  : Self-checking bench for ps2_host_tx with a clocking PS/2 device model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TMO  = 2000;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    wire        tx_ready;
    wire        busy;
    wire        tx_done;
    wire        tx_err;

    wire  ps2_clk;
    wire  ps2_data;
    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;

    pullup (ps2_clk);
    pullup (ps2_data);
    assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
    assign ps2_data = dev_data_low ? 1'b0 : 1'bz;

    int n_tests = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int t_release = 0;
    int t_err = 0;
    bit prev_pulse = 1'b0;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .CNT_W         (21)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .PS2_CLK (ps2_clk),
        .PS2_DATA(ps2_data),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .busy    (busy),
        .tx_done (tx_done),
        .tx_err  (tx_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected bits seen by the device: data LSB first, odd parity, stop
    function automatic logic [9:0] model_frame(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            prev_pulse = 1'b0;
        end else begin
            if (prev_pulse) begin
                check_val("ready_after_pulse", 32'(tx_ready), 32'd1);
                check_val("busy_after_pulse", 32'(busy), 32'd0);
            end
            if (tx_done || tx_err) begin
                check_val("done_err_exclusive", 32'(tx_done & tx_err), 32'd0);
                check_val("busy_during_pulse", 32'(busy), 32'd1);
                if (tx_done) done_cnt++;
                if (tx_err) begin
                    err_cnt++;
                    t_err = cyc;
                end
            end
            prev_pulse = tx_done | tx_err;
        end
    end

    task automatic start_req(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        check_val("ready_before_req", 32'(tx_ready), 32'd1);
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        check_val("busy_after_accept", 32'(busy), 32'd1);
    endtask

    // Called on the first INHIBIT sample; ends on the first sample after clock release
    task automatic expect_inhibit();
        int inh = 0;
        int req = 0;
        while (ps2_clk == 1'b0 && ps2_data == 1'b1 && inh < 200) begin
            inh++;
            @(negedge clk);
        end
        check_val("inhibit_len", 32'(inh), 32'(INH));
        while (ps2_clk == 1'b0 && ps2_data == 1'b0 && req < 20) begin
            req++;
            @(negedge clk);
        end
        check_val("req_len", 32'(req), 32'd1);
        check_val("start_bit", 32'({ps2_clk, ps2_data}), 32'h2);
        t_release = cyc;
    endtask

    task automatic dev_run(input int n_edges, input bit ack, output logic [9:0] bits);
        bits = '0;
        repeat (5) @(negedge clk);
        for (int e = 1; e <= n_edges; e++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            if (e <= 10) bits[e-1] = ps2_data;
            if (e == 11) dev_data_low = 1'b0;
            if (e < n_edges) begin
                repeat (HALF / 2) @(negedge clk);
                if (e == 10 && ack) dev_data_low = 1'b1;
                repeat (HALF - HALF / 2) @(negedge clk);
            end
        end
    endtask

    task automatic wait_outcome(input int d0, input int e0, input bit exp_done, input int budget);
        int k = 0;
        while (done_cnt == d0 && err_cnt == e0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        check_val("done_count", 32'(done_cnt - d0), 32'(exp_done));
        check_val("err_count", 32'(err_cnt - e0), 32'(!exp_done));
        check_val("pins_released", 32'({ps2_clk, ps2_data}), 32'h3);
        check_val("ready_when_idle", 32'(tx_ready), 32'd1);
    endtask

    task automatic run_xfer(input logic [7:0] b, input int n_edges, input bit ack);
        logic [9:0] bits;
        int d0 = done_cnt;
        int e0 = err_cnt;
        start_req(b);
        expect_inhibit();
        dev_run(n_edges, ack, bits);
        if (n_edges >= 10) check_val("frame_bits", 32'(bits), 32'(model_frame(b)));
        wait_outcome(d0, e0, (n_edges == 11) && ack, (n_edges < 11) ? TMO + 200 : 200);
        if (n_edges < 11) check_val("timeout_latency", 32'(t_err - t_release), 32'(TMO));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [9:0] bits;
        int d0;
        int e0;
        int k;

        repeat (3) @(negedge clk);
        check_val("rst_pins", 32'({ps2_clk, ps2_data}), 32'h3);
        check_val("rst_ready", 32'(tx_ready), 32'd1);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(tx_done), 32'd0);
        check_val("rst_err", 32'(tx_err), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        run_xfer(8'hED, 11, 1'b1);
        run_xfer(8'hF4, 11, 1'b1);
        run_xfer(8'hFF, 11, 1'b0);
        run_xfer(8'h00, 4, 1'b0);

        // Reset while the host is still clocking out data bits
        d0 = done_cnt;
        e0 = err_cnt;
        start_req(8'h00);
        expect_inhibit();
        dev_run(5, 1'b0, bits);
        check_val("mid_send_busy", 32'(busy), 32'd1);
        check_val("mid_send_data_low", 32'(ps2_data), 32'd0);
        rst = 1'b0;
        #1;
        check_val("async_rst_pins", 32'({ps2_clk, ps2_data}), 32'h3);
        check_val("async_rst_ready", 32'(tx_ready), 32'd1);
        check_val("async_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (60) @(negedge clk);
        check_val("rst_no_done", 32'(done_cnt - d0), 32'd0);
        check_val("rst_no_err", 32'(err_cnt - e0), 32'd0);

        // Back-to-back request held through the DONE cycle
        d0 = done_cnt;
        e0 = err_cnt;
        start_req(8'hA5);
        expect_inhibit();
        dev_run(11, 1'b1, bits);
        check_val("b2b_first_frame", 32'(bits), 32'(model_frame(8'hA5)));
        k = 0;
        while (!tx_done && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_val("b2b_done_seen", 32'(tx_done), 32'd1);
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        @(negedge clk);
        check_val("b2b_ready_idle", 32'(tx_ready), 32'd1);
        @(negedge clk);
        check_val("b2b_accepted", 32'(busy), 32'd1);
        check_val("b2b_clk_low", 32'(ps2_clk), 32'd0);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        expect_inhibit();
        dev_run(11, 1'b1, bits);
        check_val("b2b_second_frame", 32'(bits), 32'(model_frame(8'h3C)));
        wait_outcome(d0 + 1, e0, 1'b1, 200);

        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 10)) @(negedge clk);
            run_xfer(8'($urandom), 11, ($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter.
- Sends one command byte at a time to the keyboard, e.g. 0xED set-LEDs or 0xF4 enable.
- Shares the PS2_CLK/PS2_DATA pins with the existing KeyboardDecoder receiver and drives them open-drain.
- Asserts busy so upstream logic ignores receiver output while a transmission is in progress.

Parameters:
- INHIBIT_CYCLES, 10000, clk cycles PS2_CLK is held low before the start bit (100 us at 100 MHz).
- TIMEOUT_CYCLES, 1500000, max clk cycles from clock release to ACK sample (15 ms) before abort.
- CNT_W, 21, width of the shared cycle counter; must hold max(INHIBIT_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- PS2_CLK  inout  1  PS/2 clock; driven 0 or 'z' only
- PS2_DATA  inout  1  PS/2 data; driven 0 or 'z' only
- tx_data  input  8  byte to send
- tx_valid  input  1  request; sampled when tx_ready=1
- tx_ready  output  1  high only in IDLE
- busy  output  1  high in every state except IDLE
- tx_done  output  1  one-cycle pulse: byte sent and ACK received
- tx_err  output  1  one-cycle pulse: timeout or missing ACK

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; both pins 'z'; tx_ready=1; busy=0; tx_done=0; tx_err=0; counter=0; bit index=0.
  - Reset mid-transfer releases both pins immediately; no done/err pulse follows.
- Input sync: PS2_CLK and PS2_DATA pass through 2-FF synchronizers. A falling edge (fe) is sync_clk going 1→0 between consecutive clk cycles. All pin sampling uses synced values.
- Accept: tx_valid & tx_ready at a posedge latches shreg = {1'b1 stop, ~^tx_data odd parity, tx_data}, clears counter, goes to INHIBIT. tx_data changes after acceptance are ignored.
- INHIBIT: PS2_CLK=0, PS2_DATA=z; counter counts up. At counter==INHIBIT_CYCLES-1 → REQ and counter cleared.
- REQ (exactly 1 cycle): PS2_CLK=0, PS2_DATA=0 (start bit) → SEND.
- SEND:
  - PS2_CLK=z. PS2_DATA=0 while the current bit is 0, else z; current bit for index 0 is the start bit.
  - Each fe: index+1 and drive shreg[index] (data LSB first, then parity, then stop=z).
  - After the 10th fe (stop driven) → WAIT_ACK.
- WAIT_ACK: both pins z. Next fe: sync_data==0 → WAIT_IDLE; sync_data==1 → ERR.
- WAIT_IDLE: wait until sync_clk==1 and sync_data==1 → DONE.
- DONE (1 cycle): tx_done=1 → IDLE.
- ERR (1 cycle): tx_err=1; both pins z → IDLE.
- Timeout:
  - Counter restarts at entry to SEND and runs through SEND, WAIT_ACK and WAIT_IDLE.
  - Reaching TIMEOUT_CYCLES-1 in any of these → ERR, taking priority over a coincident fe.
- tx_done and tx_err are never high together. A new request is accepted the cycle IDLE is re-entered.
- The receiver sees host-driven bits on the pins; consumers gate key_valid with busy.

Test Plan:
Sim params: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=2000; bench device model toggles PS2_CLK with a 40-clk period.
1. Reset at rst=0 → pins z, tx_ready=1, busy=0, done=err=0.
2. Send 0xED; device ACKs:
   - PS2_CLK low exactly 20 cycles, then start=0.
   - Device samples on rising edges 1,0,1,1,0,1,1,1, parity 1, stop 1.
   - ACK=0 → one tx_done pulse after the lines go idle; busy falls with it.
3. Send 0xF4; device ACKs → sampled bits 0,0,1,0,1,1,1,1, parity 0; tx_done pulse.
4. Send 0xFF; device leaves DATA high at the ACK edge → tx_err pulse, no tx_done, tx_ready=1 next cycle.
5. Send 0x00; device stops clocking after 4 edges → tx_err at counter 1999 after clock release; both pins z.
6. Hold rst low for one cycle in mid-SEND (bit 5) → pins z immediately, IDLE, no pulse. Back-to-back tx_valid after DONE is accepted on the cycle IDLE is re-entered.
